drain_scheduler: RTL and testbench

DRAIN_SCHEDULER -- requirements
Module: drain_scheduler

---
 rtl/drain_scheduler.sv | 164 ++++++++++++++++
 tb/tb_drain_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/drain_scheduler.sv
// drain_scheduler: grants one bank per cycle from the request vector of the
// active drain type (READ or WRITE), using a separate round-robin pointer per
// type, and inserts a TURN_CYC-cycle turnaround bubble whenever the requested
// mode differs from the active one.
// Latency: a request visible before edge N is granted by the output register
// at edge N; grants are back to back while out_ready stays high.
// Backpressure: while out_valid && !out_ready the grant is held stable.  A mode
// change waits for that grant to be accepted before the turnaround starts.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   mode                - requested drain type from the controller
//   rd_req, wr_req      - per-bank pending read / write levels
//   out_ready           - back end accepts the current grant
//   out_valid, out_type - registered grant valid and grant type
//   out_bank            - registered granted bank index
//   turn_busy           - registered, high for the whole turnaround bubble
module drain_scheduler #(
    parameter int   BANKS    = 16,
    parameter int   TURN_CYC = 4,
    parameter logic READ     = 1'b0,
    parameter logic WRITE    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [BANKS-1:0]         rd_req,
    input  logic [BANKS-1:0]         wr_req,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic                     out_type,
    output logic [$clog2(BANKS)-1:0] out_bank,
    output logic                     turn_busy
);

    localparam int BW = $clog2(BANKS);

    typedef enum logic {SERVE, TURN} state_t;

    state_t         state, state_n;
    logic           cur_mode, cur_mode_n;
    logic           target, target_n;
    logic [3:0]     turn_cnt, turn_cnt_n;
    logic [BW-1:0]  rd_ptr, rd_ptr_n;
    logic [BW-1:0]  wr_ptr, wr_ptr_n;
    logic           out_valid_n;
    logic           out_type_n;
    logic [BW-1:0]  out_bank_n;
    logic           turn_busy_n;

    // Type whose requests are eligible this cycle.  On the last turnaround
    // cycle this is already the target, so the first grant of the new type
    // lands on the exit edge and the bubble is exactly TURN_CYC cycles.
    logic           grant_type;
    logic [BANKS-1:0] grant_vec;
    logic [BW-1:0]  grant_ptr;
    logic           hit;
    logic [BW-1:0]  hit_idx;
    logic           out_free;

    // First set bit searching upward from ptr+1, wrapping; ptr itself is
    // visited last so a lone requester at the pointer is still found.
    always_comb begin
        int idx;
        hit     = 1'b0;
        hit_idx = '0;
        idx     = 0;
        for (int k = 1; k <= BANKS; k++) begin
            idx = (int'(grant_ptr) + k) % BANKS;
            if (!hit && grant_vec[idx]) begin
                hit     = 1'b1;
                hit_idx = idx[BW-1:0];
            end
        end
    end

    always_comb begin
        grant_type = (state == TURN) ? target : cur_mode;
        grant_vec  = (grant_type == WRITE) ? wr_req : rd_req;
        grant_ptr  = (grant_type == WRITE) ? wr_ptr : rd_ptr;
        out_free   = !out_valid || out_ready;
    end

    always_comb begin
        state_n     = state;
        cur_mode_n  = cur_mode;
        target_n    = target;
        turn_cnt_n  = turn_cnt;
        rd_ptr_n    = rd_ptr;
        wr_ptr_n    = wr_ptr;
        out_valid_n = out_valid;
        out_type_n  = out_type;
        out_bank_n  = out_bank;
        turn_busy_n = turn_busy;

        case (state)
            SERVE: begin
                if (out_free) begin
                    if (mode != cur_mode) begin
                        state_n     = TURN;
                        target_n    = mode;
                        turn_cnt_n  = 4'(TURN_CYC - 1);
                        out_valid_n = 1'b0;
                        turn_busy_n = 1'b1;
                    end else if (hit) begin
                        out_valid_n = 1'b1;
                        out_type_n  = grant_type;
                        out_bank_n  = hit_idx;
                        if (grant_type == WRITE) wr_ptr_n = hit_idx;
                        else                     rd_ptr_n = hit_idx;
                    end else begin
                        out_valid_n = 1'b0;
                    end
                end
            end
            TURN: begin
                out_valid_n = 1'b0;
                if (turn_cnt == 4'd0) begin
                    state_n     = SERVE;
                    cur_mode_n  = target;
                    turn_busy_n = 1'b0;
                    // If mode already moved away again, skip the grant and
                    // let SERVE start the next turnaround.
                    if (mode == target && hit) begin
                        out_valid_n = 1'b1;
                        out_type_n  = grant_type;
                        out_bank_n  = hit_idx;
                        if (grant_type == WRITE) wr_ptr_n = hit_idx;
                        else                     rd_ptr_n = hit_idx;
                    end
                end else begin
                    turn_cnt_n = turn_cnt - 4'd1;
                end
            end
            default: state_n = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SERVE;
            cur_mode  <= READ;
            target    <= READ;
            turn_cnt  <= '0;
            rd_ptr    <= BW'(BANKS - 1);
            wr_ptr    <= BW'(BANKS - 1);
            out_valid <= 1'b0;
            out_type  <= READ;
            out_bank  <= '0;
            turn_busy <= 1'b0;
        end else begin
            state     <= state_n;
            cur_mode  <= cur_mode_n;
            target    <= target_n;
            turn_cnt  <= turn_cnt_n;
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr_n;
            out_valid <= out_valid_n;
            out_type  <= out_type_n;
            out_bank  <= out_bank_n;
            turn_busy <= turn_busy_n;
        end
    end

endmodule

// File: tb/tb_drain_scheduler.sv
// Bench for drain_scheduler: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_drain_scheduler;

    localparam int BANKS = 16;
    localparam int TURN  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic [BANKS-1:0]  rd_req;
    logic [BANKS-1:0]  wr_req;
    logic              out_ready;
    logic              out_valid;
    logic              out_type;
    logic [3:0]        out_bank;
    logic              turn_busy;

    int checks = 0;
    int errors = 0;

    drain_scheduler #(.BANKS(BANKS), .TURN_CYC(TURN), .READ(1'b0), .WRITE(1'b1)) dut (
        .clk(clk), .rst(rst), .mode(mode), .rd_req(rd_req), .wr_req(wr_req),
        .out_ready(out_ready), .out_valid(out_valid), .out_type(out_type),
        .out_bank(out_bank), .turn_busy(turn_busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_ok = 0;
    bit m_ov, m_type, m_cur, m_target;
    int m_bank, m_left, m_rptr, m_wptr;

    task automatic m_grant(input bit ty);
        logic [BANKS-1:0] v;
        int p, b;
        bit done;
        v    = ty ? wr_req : rd_req;
        p    = ty ? m_wptr : m_rptr;
        done = 0;
        m_ov = 0;
        for (int k = 1; k <= BANKS; k++) begin
            b = (p + k) % BANKS;
            if (!done && v[b]) begin
                done   = 1;
                m_ov   = 1;
                m_type = ty;
                m_bank = b;
                if (ty) m_wptr = b; else m_rptr = b;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1; m_ov = 0; m_type = 0; m_bank = 0; m_cur = 0; m_target = 0;
            m_left = 0; m_rptr = BANKS - 1; m_wptr = BANKS - 1;
        end else if (m_ok) begin
            if (m_left > 0) begin
                m_left = m_left - 1;
                m_ov   = 0;
                if (m_left == 0) begin
                    m_cur = m_target;
                    if (mode == m_cur) m_grant(m_cur);
                end
            end else if (!m_ov || out_ready) begin
                if (mode != m_cur) begin
                    m_target = mode;
                    m_left   = TURN;
                    m_ov     = 0;
                end else begin
                    m_grant(m_cur);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_ok) begin
            checks++;
            if (out_valid !== m_ov || turn_busy !== (m_left > 0) ||
                (m_ov && (out_type !== m_type || out_bank !== 4'(m_bank)))) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got v=%b ty=%b bank=%0d busy=%b expected v=%b ty=%b bank=%0d busy=%b",
                         $time, out_valid, out_type, out_bank, turn_busy,
                         m_ov, m_type, m_bank, (m_left > 0));
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int exp_seq [4];
        exp_seq = '{0, 4, 0, 4};
        rst = 1; mode = 0; rd_req = '0; wr_req = '0; out_ready = 1;
        repeat (2) cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_type", out_type, 0);
        chk("rst_bank", out_bank, 0);
        chk("rst_busy", turn_busy, 0);
        rst = 0;

        // Round robin over banks 0 and 4
        rd_req = 16'h0011;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_valid", out_valid, 1);
            chk("rr_type", out_type, 0);
            chk("rr_bank", out_bank, exp_seq[i]);
        end
        rd_req = '0;
        cyc();
        chk("rr_idle", out_valid, 0);

        // Writes are ignored in READ mode
        wr_req = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("wr_ignored", out_valid, 0);
        end
        wr_req = '0;

        // READ -> WRITE turnaround
        mode = 1; wr_req = 16'h0020;
        for (int i = 0; i < TURN; i++) begin
            cyc();
            chk("turn_busy", turn_busy, 1);
            chk("turn_valid", out_valid, 0);
        end
        cyc();
        chk("turn_end_busy", turn_busy, 0);
        chk("first_wr_valid", out_valid, 1);
        chk("first_wr_type", out_type, 1);
        chk("first_wr_bank", out_bank, 5);
        wr_req = '0; mode = 0;
        repeat (7) cyc();

        // Pending READ grant held across a mode change
        out_ready = 0; rd_req = 16'h0008;
        cyc();
        chk("hold_valid", out_valid, 1);
        chk("hold_bank", out_bank, 3);
        mode = 1; wr_req = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("held_valid", out_valid, 1);
            chk("held_type", out_type, 0);
            chk("held_bank", out_bank, 3);
            chk("held_busy", turn_busy, 0);
        end
        out_ready = 1;
        cyc();
        chk("accept_turn_busy", turn_busy, 1);
        chk("accept_no_read", out_valid, 0);
        repeat (3) cyc();
        chk("accept_turn_busy4", turn_busy, 1);
        cyc();
        chk("post_wr_valid", out_valid, 1);
        chk("post_wr_type", out_type, 1);
        chk("post_wr_bank", out_bank, 0);
        wr_req = '0; rd_req = '0; mode = 0;
        repeat (7) cyc();

        // Pointer wrap
        rd_req = 16'h8000;
        cyc();
        chk("wrap_valid15", out_valid, 1);
        chk("wrap_bank15", out_bank, 15);
        rd_req = 16'h8001;
        cyc();
        chk("wrap_bank0", out_bank, 0);
        rd_req = '0;
        cyc();

        // Reset during the second turnaround cycle
        mode = 1;
        cyc();
        chk("rst_turn_busy1", turn_busy, 1);
        cyc();
        rst = 1; mode = 0; rd_req = 16'h0011;
        cyc();
        chk("rst_turn_valid", out_valid, 0);
        chk("rst_turn_busy", turn_busy, 0);
        rst = 0;
        cyc();
        chk("rst_regrant_valid", out_valid, 1);
        chk("rst_regrant_type", out_type, 0);
        chk("rst_regrant_bank", out_bank, 0);
        cyc();
        chk("rst_regrant_bank4", out_bank, 4);
        rd_req = '0;
        cyc();

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            rd_req    = ($urandom_range(0, 3) == 0) ? '0 : BANKS'($urandom & $urandom);
            wr_req    = ($urandom_range(0, 3) == 0) ? '0 : BANKS'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
